// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/response bundle between issue logic and alu_mdu
// Ports: valid_in/op/a/b carry a request (master drives); ready, valid_out,
// out/zero/ovf and the architectural hi/lo registers flow back (slave drives).
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic             valid_in;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             valid_out;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ovf;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output valid_in, op, a, b,
                    input  ready, valid_out, out, zero, ovf, hi, lo);
    modport slave  (input  valid_in, op, a, b,
                    output ready, valid_out, out, zero, ovf, hi, lo);
endinterface

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU with iterative multiply/divide and HI/LO
// Ports: clk, rst_n (async assert, active-low), bus (alu_mdu_if.slave):
// single-cycle ALU ops complete one edge after acceptance; MULT/MULTU/DIV/DIVU
// hold ready low for WIDTH+1 edges and then update hi/lo and out together.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
    state_t state, state_nx;

    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
    logic               is_div, neg_res, neg_rem, div0;
    logic               valid_out_r, zero_r, ovf_r;
    logic [WIDTH-1:0]   out_r, hi_r, lo_r;

    logic accept, is_mdu, is_signed;
    assign accept    = bus.valid_in && (state == IDLE);
    assign is_mdu    = (bus.op[4:2] == 3'b100);
    assign is_signed = !bus.op[0];            // MULT=16, DIV=18 are the signed forms

    // Single-cycle ALU
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SW-1:0]    shamt;
    logic             ovf_add, ovf_sub, alu_ovf;
    assign sum     = bus.a + bus.b;
    assign diff    = bus.a - bus.b;
    assign shamt   = bus.b[SW-1:0];
    assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            5'd0:  begin alu_res = sum;  alu_ovf = ovf_add; end
            5'd1:  begin alu_res = diff; alu_ovf = ovf_sub; end
            5'd2:  alu_res = bus.a & bus.b;
            5'd3:  alu_res = bus.a | bus.b;
            5'd4:  alu_res = ~(bus.a | bus.b);
            5'd5:  alu_res = bus.a ^ bus.b;
            5'd6:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            5'd7:  alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            5'd8:  alu_res = bus.a << shamt;
            5'd9:  alu_res = bus.a >> shamt;
            5'd10: alu_res = $unsigned($signed(bus.a) >>> shamt);
            5'd12: alu_res = hi_r;
            5'd13: alu_res = lo_r;
            5'd14, 5'd15: alu_res = bus.a;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes; the unsigned view of -MIN is MIN itself, which is
    // exactly the magnitude the iteration needs.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier LSB is set, then shift the whole pair right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the
    // remainder, keep the difference only if it did not go negative.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign div_next = rem_diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                    : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign fix-up; a zero divisor yields all-ones quotient and the remainder
    // path reproduces the original dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q, r, fix_hi, fix_lo;
    assign prod_fix = neg_res ? -acc : acc;
    assign q        = acc[WIDTH-1:0];
    assign r        = acc[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? (div0 ? {WIDTH{1'b1}} : (neg_res ? -q : q)) : prod_fix[WIDTH-1:0];
    assign fix_hi   = is_div ? (neg_rem ? -r : r) : prod_fix[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mdu) state_nx = BUSY;
            BUSY:    if (cnt == SW'(WIDTH-1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0; acc <= '0; opb <= '0;
            is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0; div0 <= 1'b0;
            valid_out_r <= 1'b0; out_r <= '0; zero_r <= 1'b1; ovf_r <= 1'b0;
            hi_r <= '0; lo_r <= '0;
        end else begin
            valid_out_r <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_mdu) begin
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opb     <= b_mag;
                        cnt     <= '0;
                        is_div  <= bus.op[1];
                        neg_res <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem <= is_signed && bus.a[WIDTH-1];
                        div0    <= (bus.b == '0);
                    end else begin
                        out_r       <= alu_res;
                        zero_r      <= (alu_res == '0);
                        ovf_r       <= alu_ovf;
                        valid_out_r <= 1'b1;
                        if (bus.op == 5'd14) hi_r <= bus.a;
                        if (bus.op == 5'd15) lo_r <= bus.a;
                    end
                end
                BUSY: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_r        <= fix_hi;
                    lo_r        <= fix_lo;
                    out_r       <= fix_lo;
                    zero_r      <= (fix_lo == '0);
                    ovf_r       <= 1'b0;
                    valid_out_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.valid_out = valid_out_r;
    assign bus.out       = out_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
endmodule
